// File: rtl/tdm_pkg.sv
// tdm_pkg
//   Constants and state encoding shared by the 16-channel TDM link
//   (the tdm_demux16 receiver and the matching transmitter).
//   N     : number of channels (power of two)
//   SEL_W : channel counter width, log2(N)
package tdm_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux16_demux1to16.sv
// demux1to16
//   Combinational 4-to-16 one-hot decoder. Produces the per-slot write enables
//   for the receiver's shadow frame register.
// Ports:
//   sel : slot index to enable
//   en  : global enable; when low, no output is asserted
//   y   : one-hot slot enables, y[k] selects slot k
module demux1to16
  import tdm_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [0:N-1]     y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16
//   Receive end of the 16-channel TDM link. Locks onto the frame-sync marker,
//   steers each accepted bit into its channel slot and presents a complete
//   frame with a one-cycle valid strobe. Early syncs abort the partial frame
//   and raise a one-cycle err strobe.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : synchronous active-low reset
//   d      : serial data bit for the current slot
//   en     : slot strobe, d and fsync are sampled only when high
//   fsync  : frame sync, marks the current bit as channel 0
//   Q      : last complete frame, Q[k] = channel k
//   valid  : one-cycle pulse when Q is updated
//   err    : one-cycle pulse when a frame is aborted by an early fsync
//   ch     : slot the next accepted bit will be written to
//   locked : high while in SYNC
//
// state | meaning
// HUNT  | waiting for the first fsync, all bits discarded
// SYNC  | framed, every accepted bit is written to its slot
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             d,
  input  logic             en,
  input  logic             fsync,
  output logic [0:N-1]     Q,
  output logic             valid,
  output logic             err,
  output logic [SEL_W-1:0] ch,
  output logic             locked
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic [SEL_W-1:0] wr_sel;
  logic             accept;
  logic             early;
  logic             frame_end;
  logic [0:N-1]     wr_en;
  logic [0:N-1]     shadow;
  // Frame completion and early sync are both reported one edge after the
  // edge that samples the causing bit, so each goes through a pending stage.
  logic             done_pend;
  logic             early_pend;

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    wr_sel    = ch;
    accept    = 1'b0;
    early     = 1'b0;
    frame_end = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (fsync) begin
            accept    = 1'b1;
            wr_sel    = '0;
            ch_nxt    = SEL_W'(1);
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          accept = 1'b1;
          if (fsync) begin
            // A sync anywhere but slot 0 restarts the frame.
            wr_sel = '0;
            ch_nxt = SEL_W'(1);
            early  = (ch != '0);
          end else begin
            ch_nxt    = ch + 1'b1;
            frame_end = (ch == SEL_W'(N - 1));
          end
        end
      endcase
    end
  end

  demux1to16 u_demux (
    .sel (wr_sel),
    .en  (accept),
    .y   (wr_en)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= HUNT;
      ch         <= '0;
      shadow     <= '0;
      Q          <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
      done_pend  <= 1'b0;
      early_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      for (int k = 0; k < N; k++) begin
        if (wr_en[k]) begin
          shadow[k] <= d;
        end
      end
      done_pend  <= frame_end;
      early_pend <= early;
      valid      <= done_pend;
      err        <= early_pend;
      // shadow still holds the finished frame here; a new slot-0 write on
      // this same edge lands after the copy.
      if (done_pend) begin
        Q <= shadow;
      end
    end
  end

  assign locked = (state == SYNC);

endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16
//   Directed bench for tdm_demux16. A frame-level reference model (bit queue
//   per frame) is compared against the DUT on every cycle, and literal
//   expectations pin the model at key points.
module tb_tdm_demux16;

  logic        Clock;
  logic        Resetn;
  logic        d;
  logic        en;
  logic        fsync;
  logic [0:15] Q;
  logic        valid;
  logic        err;
  logic [3:0]  ch;
  logic        locked;

  tdm_demux16 dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .d      (d),
    .en     (en),
    .fsync  (fsync),
    .Q      (Q),
    .valid  (valid),
    .err    (err),
    .ch     (ch),
    .locked (locked)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          cur[$];
  logic        m_locked = 1'b0;
  logic [0:15] m_q      = '0;
  logic        m_valid  = 1'b0;
  logic        m_err    = 1'b0;
  logic [3:0]  m_ch     = '0;
  logic        pend_v   = 1'b0;
  logic        pend_e   = 1'b0;
  logic [0:15] pend_frame = '0;
  int          cyc_n    = 0;

  always @(posedge Clock) begin
    cyc_n++;
    if (!Resetn) begin
      cur.delete();
      m_locked = 1'b0;
      m_q      = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      pend_v   = 1'b0;
      pend_e   = 1'b0;
    end else begin
      m_valid = pend_v;
      m_err   = pend_e;
      if (pend_v) m_q = pend_frame;
      pend_v = 1'b0;
      pend_e = 1'b0;
      if (en) begin
        if (fsync) begin
          if (m_locked && cur.size() != 0) pend_e = 1'b1;
          cur.delete();
          cur.push_back(d);
          m_locked = 1'b1;
        end else if (m_locked) begin
          cur.push_back(d);
          if (cur.size() == 16) begin
            for (int k = 0; k < 16; k++) pend_frame[k] = cur[k];
            pend_v = 1'b1;
            cur.delete();
          end
        end
      end
    end
    m_ch = 4'(cur.size());
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_on = 1'b0;
  int vcount = 0;
  int ecount = 0;
  int vt[$];

  always @(negedge Clock) begin
    if (cmp_on) begin
      check("cmp_q",      32'(Q),      32'(m_q));
      check("cmp_valid",  32'(valid),  32'(m_valid));
      check("cmp_err",    32'(err),    32'(m_err));
      check("cmp_ch",     32'(ch),     32'(m_ch));
      check("cmp_locked", 32'(locked), 32'(m_locked));
      if (valid === 1'b1) begin
        vcount++;
        vt.push_back(cyc_n);
      end
      if (err === 1'b1) ecount++;
    end
  end

  // ---------------- stimulus ----------------
  int last_acc = 0;
  int fs_edge  = 0;

  // Inputs change just after a falling edge and are sampled at the next rise.
  task automatic cyc(input logic b, input logic e, input logic f);
    d = b; en = e; fsync = f;
    @(negedge Clock);
    #1;
  endtask

  task automatic send_frame(input logic [0:15] p, input bit with_sync, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      cyc(p[k], 1'b1, with_sync && (k == 0));
      last_acc = cyc_n;
      if (k == 0) fs_edge = cyc_n;
      if (gaps) cyc(1'b1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int v0, e0, fs_first;
  logic [0:15] part;

  initial begin
    Resetn = 1'b0; d = 1'b0; en = 1'b0; fsync = 1'b0;
    @(negedge Clock); #1;
    cyc(1'b0, 1'b0, 1'b0);
    cmp_on = 1'b1;
    check("rst_q",      32'(Q),      32'h0);
    check("rst_valid",  32'(valid),  32'h0);
    check("rst_ch",     32'(ch),     32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    Resetn = 1'b1;

    // bits while hunting are discarded
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    check("hunt_locked", 32'(locked), 32'h0);
    check("hunt_ch",     32'(ch),     32'h0);
    check("hunt_valid_cnt", 32'(vcount), 32'h0);

    // three clean back-to-back frames
    v0 = vcount;
    send_frame(16'hA5C3, 1'b1, 1'b0);
    fs_first = fs_edge;
    send_frame(16'hA5C3, 1'b1, 1'b0);
    send_frame(16'hA5C3, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("clean_valid_cnt", 32'(vcount - v0), 32'd3);
    check("clean_first_valid", 32'(vt[v0] - fs_first), 32'd16);
    check("clean_spacing1", 32'(vt[v0+1] - vt[v0]), 32'd16);
    check("clean_spacing2", 32'(vt[v0+2] - vt[v0+1]), 32'd16);
    check("clean_q", 32'(Q), 32'hA5C3);

    // en every other cycle (fsync and d toggled during gaps must be ignored)
    v0 = vcount;
    send_frame(16'h0F0F, 1'b1, 1'b1);
    check("gap_valid_edge", 32'(vt[v0] - last_acc), 32'd1);
    check("gap_q", 32'(Q), 32'h0F0F);
    check("gap_err_cnt", 32'(ecount), 32'h0);

    // early sync at ch=9, then full frame
    v0 = vcount; e0 = ecount;
    part = 16'hFFFF;
    for (int k = 0; k < 9; k++) cyc(part[k], 1'b1, k == 0);
    check("early_ch9", 32'(ch), 32'd9);
    send_frame(16'h1234, 1'b1, 1'b0);
    check("early_q_held", 32'(Q), 32'h0F0F);
    check("early_no_valid", 32'(vcount - v0), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("early_q", 32'(Q), 32'h1234);
    check("early_valid_cnt", 32'(vcount - v0), 32'd1);
    check("early_err_cnt", 32'(ecount - e0), 32'd1);

    // reset mid-frame at ch=7; reset overrides en/fsync
    part = 16'hBEEF;
    for (int k = 0; k < 7; k++) cyc(part[k], 1'b1, k == 0);
    check("mid_ch7", 32'(ch), 32'd7);
    Resetn = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    check("mid_rst_q",      32'(Q),      32'h0);
    check("mid_rst_ch",     32'(ch),     32'h0);
    check("mid_rst_locked", 32'(locked), 32'h0);
    check("mid_rst_valid",  32'(valid),  32'h0);
    check("mid_rst_err",    32'(err),    32'h0);
    Resetn = 1'b1;
    v0 = vcount;
    send_frame(16'h5A5A, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("post_rst_q", 32'(Q), 32'h5A5A);
    check("post_rst_valid_cnt", 32'(vcount - v0), 32'd1);

    // free-run: no fsync on the next two frames
    v0 = vcount; e0 = ecount;
    send_frame(16'hC0DE, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("free_q1", 32'(Q), 32'hC0DE);
    send_frame(16'h3C96, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("free_q2", 32'(Q), 32'h3C96);
    check("free_valid_cnt", 32'(vcount - v0), 32'd2);
    check("free_err_cnt", 32'(ecount - e0), 32'd0);
    check("free_locked", 32'(locked), 32'h1);

    cyc(1'b0, 1'b0, 1'b0);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
